// File: rtl/csr_pkg.sv
// csr_pkg: shared encodings for the CSR access controller.
// Holds request op codes, FSM state codes, the privilege-fault exception
// code and the CSR numbers used by the surrounding core.
package csr_pkg;

  // Request op encodings as presented on req_op
  localparam logic [1:0] OP_CSRRD   = 2'b00;
  localparam logic [1:0] OP_CSRWR   = 2'b01;
  localparam logic [1:0] OP_CSRXCHG = 2'b10;
  localparam logic [1:0] OP_ERTN    = 2'b11;

  // Controller FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_ERTN  = 3'd3;
  localparam logic [2:0] ST_EXC   = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  // Instruction privilege error exception code
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  // CSR numbers known to the core
  localparam logic [13:0] CSR_CRMD  = 14'h0000;
  localparam logic [13:0] CSR_PRMD  = 14'h0001;
  localparam logic [13:0] CSR_ECFG  = 14'h0004;
  localparam logic [13:0] CSR_ESTAT = 14'h0005;
  localparam logic [13:0] CSR_ERA   = 14'h0006;
  localparam logic [13:0] CSR_SAVE0 = 14'h0030;
  localparam logic [13:0] CSR_SAVE1 = 14'h0031;
  localparam logic [13:0] CSR_SAVE2 = 14'h0032;
  localparam logic [13:0] CSR_SAVE3 = 14'h0033;

endpackage

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences csrrd / csrwr / csrxchg / ertn requests against
// the CSR file. A request is accepted in IDLE, the old CSR value is read,
// optionally written back with a mask, and a single response is returned.
// Optional feature: define CSR_PRIV_CHECK_EN to raise an instruction
// privilege exception (IPE) for any request issued with cur_plv != 0.
module csr_access_ctrl
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [13:0] req_num,
  input  logic [31:0] req_rd_val,
  input  logic [31:0] req_rj_val,
  input  logic [31:0] req_pc,
  input  logic [1:0]  cur_plv,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_ex,
  input  logic        flush,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        ertn_flush,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr
);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [1:0]  op_q;
  logic [13:0] num_q;
  logic [31:0] rd_val_q;
  logic [31:0] rj_val_q;
  logic [31:0] pc_q;
  logic [31:0] rdata_q;
  logic        ex_q;
  logic        accept;
  logic        take;
  logic        priv_fault;

  // req_ready is held low while reset is asserted so every output reads 0
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // A flush coinciding with the handshake cancels the request outright
  assign take      = accept && !flush;

`ifdef CSR_PRIV_CHECK_EN
  assign priv_fault = (cur_plv != 2'b00);
`else
  logic unused_priv;
  assign priv_fault  = 1'b0;
  assign unused_priv = ^{cur_plv, pc_q};
`endif

  // Next-state selection; flush cancels any in-flight work back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take) begin
          if (priv_fault)
            state_nxt = ST_EXC;
          else if (req_op == OP_ERTN)
            state_nxt = ST_ERTN;
          else
            state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (flush)
          state_nxt = ST_IDLE;
        else if (op_q == OP_CSRRD)
          state_nxt = ST_RESP;
        else
          state_nxt = ST_WRITE;
      end
      ST_WRITE: state_nxt = flush ? ST_IDLE : ST_RESP;
      ST_ERTN:  state_nxt = flush ? ST_IDLE : ST_RESP;
      ST_EXC:   state_nxt = flush ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        if (flush || resp_ready)
          state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register, request capture and response data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      num_q    <= '0;
      rd_val_q <= '0;
      rj_val_q <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      ex_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_q     <= req_op;
        num_q    <= req_num;
        rd_val_q <= req_rd_val;
        rj_val_q <= req_rj_val;
        pc_q     <= req_pc;
        rdata_q  <= '0;
        ex_q     <= 1'b0;
      end
      case (state)
        ST_READ: rdata_q <= csr_rvalue;
        ST_EXC:  ex_q    <= 1'b1;
        default: ;
      endcase
    end
  end

  // CSR file read/write strobes; side-effecting strobes die on flush or reset
  always_comb begin
    csr_num    = (state == ST_IDLE) ? 14'd0 : num_q;
    csr_re     = (state == ST_READ) && !rst;
    csr_we     = (state == ST_WRITE) && !flush && !rst;
    csr_wmask  = '0;
    csr_wvalue = '0;
    if (state == ST_WRITE) begin
      csr_wmask  = (op_q == OP_CSRWR) ? 32'hFFFF_FFFF : rj_val_q;
      csr_wvalue = rd_val_q;
    end
    ertn_flush = (state == ST_ERTN) && !flush && !rst;
  end

  // Response port is only non-zero while a response is being offered
  always_comb begin
    resp_valid = (state == ST_RESP);
    resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
    resp_ex    = (state == ST_RESP) ? ex_q : 1'b0;
  end

`ifdef CSR_PRIV_CHECK_EN
  // Exception report towards writeback while in EXC
  always_comb begin
    wb_ex    = (state == ST_EXC) && !flush && !rst;
    wb_ecode = (state == ST_EXC) ? ECODE_IPE : 6'd0;
    wb_pc    = (state == ST_EXC) ? pc_q : 32'd0;
  end
`else
  // No privilege checking: the exception report stays quiet
  always_comb begin
    wb_ex    = 1'b0;
    wb_ecode = 6'd0;
    wb_pc    = 32'd0;
  end
`endif

  assign wb_esubcode = 9'd0;
  assign wb_vaddr    = 32'd0;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: self-checking bench for csr_access_ctrl.
// Expected behaviour comes from a transaction-level model of the access
// rules; a small CSR array plays the CSR file. Build with CSR_PRIV_CHECK_EN
// defined to exercise the privilege-fault path.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [13:0] req_num = '0;
  logic [31:0] req_rd_val = '0;
  logic [31:0] req_rj_val = '0;
  logic [31:0] req_pc = '0;
  logic [1:0]  cur_plv = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_ex;
  logic        flush = 1'b0;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        ertn_flush;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, XCHG = 2'b10, ERTN = 2'b11;
`ifdef CSR_PRIV_CHECK_EN
  localparam bit PRIV_EN = 1'b1;
`else
  localparam bit PRIV_EN = 1'b0;
`endif

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_num(req_num), .req_rd_val(req_rd_val), .req_rj_val(req_rj_val),
    .req_pc(req_pc), .cur_plv(cur_plv),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_ex(resp_ex), .flush(flush),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .ertn_flush(ertn_flush), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr)
  );

  always #5 clk = ~clk;

  // CSR file stand-in, only written from the stimulus process
  logic [31:0] csr_mem [64];
  assign csr_rvalue = csr_mem[csr_num[5:0]];

  logic [194:0] others;
  assign others = {resp_valid, resp_rdata, resp_ex, csr_re, csr_num, csr_we,
                   csr_wmask, csr_wvalue, ertn_flush, wb_ex, wb_ecode,
                   wb_esubcode, wb_pc, wb_vaddr};

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int resp_cyc; int re_cnt; int re_cyc; int we_cnt; int we_cyc;
    logic [31:0] we_mask; logic [31:0] we_val;
    int ertn_cnt; int ertn_cyc; int ex_cnt; int ex_cyc;
    logic [5:0] ex_code; logic [31:0] ex_pc;
    logic [31:0] rdata; logic ex;
    bit start_ready; bit hold_ok; bit side_ok;
  } obs_t;

  typedef struct {
    int lat; int re_cnt; int we_cnt; int ertn_cnt; int ex_cnt;
    logic [31:0] mask; logic [31:0] wval; logic [31:0] rdata; logic ex;
    logic [31:0] newval;
  } exp_t;

  obs_t obs;
  logic [13:0] txn_num;

  // Transaction-level expectation for one request
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] rd,
                                 input logic [31:0] rj, input logic [31:0] old,
                                 input logic [1:0] plv);
    exp_t e;
    e = '{default: 0};
    e.newval = old;
    if (PRIV_EN && plv != 2'd0) begin
      e.lat = 2; e.ex_cnt = 1; e.ex = 1'b1;
    end else if (op == ERTN) begin
      e.lat = 2; e.ertn_cnt = 1;
    end else begin
      e.re_cnt = 1; e.rdata = old;
      if (op == RD) e.lat = 2;
      else begin
        e.lat = 3; e.we_cnt = 1; e.wval = rd;
        e.mask = (op == WR) ? 32'hFFFF_FFFF : rj;
        e.newval = (old & ~e.mask) | (rd & e.mask);
      end
    end
    return e;
  endfunction

  // Record strobes seen in the current cycle and apply CSR writes
  task automatic sample(input int cyc);
    if (csr_re) begin obs.re_cnt++; obs.re_cyc = cyc; end
    if (csr_we) begin
      obs.we_cnt++; obs.we_cyc = cyc; obs.we_mask = csr_wmask; obs.we_val = csr_wvalue;
      csr_mem[csr_num[5:0]] = (csr_mem[csr_num[5:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end
    if (ertn_flush) begin obs.ertn_cnt++; obs.ertn_cyc = cyc; end
    if (wb_ex) begin obs.ex_cnt++; obs.ex_cyc = cyc; obs.ex_code = wb_ecode; obs.ex_pc = wb_pc; end
    if (wb_vaddr !== 32'd0 || wb_esubcode !== 9'd0) obs.side_ok = 1'b0;
    if (!csr_we && (csr_wmask !== 32'd0 || csr_wvalue !== 32'd0)) obs.side_ok = 1'b0;
    if ((csr_re || csr_we) && csr_num !== txn_num) obs.side_ok = 1'b0;
    if (!wb_ex && (wb_ecode !== 6'd0 || wb_pc !== 32'd0)) obs.side_ok = 1'b0;
  endtask

  // Present a request at a negedge and clock it through the handshake
  task automatic start_req(input logic [1:0] op, input logic [13:0] num,
                           input logic [31:0] rd, input logic [31:0] rj,
                           input logic [31:0] pc, input logic [1:0] plv);
    req_valid = 1'b1; req_op = op; req_num = num;
    req_rd_val = rd; req_rj_val = rj; req_pc = pc; cur_plv = plv;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_num = 14'($urandom);
    req_rd_val = $urandom; req_rj_val = $urandom; req_pc = $urandom;
    cur_plv = 2'($urandom);
  endtask

  // Run one complete transaction and collect observations (cycle 1 = first after accept)
  task automatic run_txn(input logic [1:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj,
                         input logic [31:0] pc, input logic [1:0] plv,
                         input int delay);
    int cyc;
    bit done;
    obs = '{default: 0};
    obs.resp_cyc = -1; obs.hold_ok = 1'b1; obs.side_ok = 1'b1;
    txn_num = num;
    obs.start_ready = req_ready;
    start_req(op, num, rd, rj, pc, plv);
    cyc = 1; done = 1'b0;
    while (!done && cyc <= 12) begin
      sample(cyc);
      if (resp_valid) begin
        obs.resp_cyc = cyc; obs.rdata = resp_rdata; obs.ex = resp_ex;
        for (int d = 0; d < delay; d++) begin
          if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== obs.rdata || resp_ex !== obs.ex)
            obs.hold_ok = 1'b0;
          @(posedge clk); @(negedge clk);
          sample(cyc + d + 1);
        end
        if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== obs.rdata || resp_ex !== obs.ex)
          obs.hold_ok = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk); @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({req_ready, others} !== '0) begin n_err++; $display("[TB] FAIL reset_outputs: got %h want 0", {req_ready, others}); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (others !== '0) begin n_err++; $display("[TB] FAIL reset_idle_outputs: got %h want 0", others); end
  endtask

  task automatic test_csrrd_save0();
    csr_mem[6'h30] = 32'h1234_5678;
    run_txn(RD, 14'h0030, 32'hDEAD_BEEF, 32'hCAFE_0000, 32'h1C00_0000, 2'd0, 0);
    n_cmp++; if (obs.resp_cyc !== 2) begin n_err++; $display("[TB] FAIL rd_latency: got %0d want 2", obs.resp_cyc); end
    n_cmp++; if (obs.re_cnt !== 1 || obs.re_cyc !== 1) begin n_err++; $display("[TB] FAIL rd_re: got cnt %0d cyc %0d want 1/1", obs.re_cnt, obs.re_cyc); end
    n_cmp++; if (obs.we_cnt !== 0) begin n_err++; $display("[TB] FAIL rd_no_we: got %0d want 0", obs.we_cnt); end
    n_cmp++; if (obs.rdata !== 32'h1234_5678) begin n_err++; $display("[TB] FAIL rd_rdata: got %h want 12345678", obs.rdata); end
  endtask

  task automatic test_csrxchg_ecfg();
    csr_mem[6'h04] = 32'h0000_0005;
    run_txn(XCHG, 14'h0004, 32'h0000_0FFF, 32'h0000_00F0, 32'h1C00_0010, 2'd0, 1);
    n_cmp++; if (obs.we_cnt !== 1 || obs.we_cyc !== 2) begin n_err++; $display("[TB] FAIL xchg_we: got cnt %0d cyc %0d want 1/2", obs.we_cnt, obs.we_cyc); end
    n_cmp++; if (obs.we_mask !== 32'h0000_00F0 || obs.we_val !== 32'h0000_0FFF) begin n_err++; $display("[TB] FAIL xchg_mask_val: got %h/%h want 000000f0/00000fff", obs.we_mask, obs.we_val); end
    n_cmp++; if (obs.resp_cyc !== 3 || obs.rdata !== 32'h5) begin n_err++; $display("[TB] FAIL xchg_resp: got cyc %0d rdata %h want 3/5", obs.resp_cyc, obs.rdata); end
    n_cmp++; if (csr_mem[6'h04] !== 32'h0000_00F5) begin n_err++; $display("[TB] FAIL xchg_csr_value: got %h want 000000f5", csr_mem[6'h04]); end
  endtask

  task automatic test_ertn_hold();
    run_txn(ERTN, 14'h0006, 32'h1111_1111, 32'h2222_2222, 32'h1C00_0020, 2'd0, 4);
    n_cmp++; if (obs.ertn_cnt !== 1 || obs.ertn_cyc !== 1) begin n_err++; $display("[TB] FAIL ertn_pulse: got cnt %0d cyc %0d want 1/1", obs.ertn_cnt, obs.ertn_cyc); end
    n_cmp++; if (obs.resp_cyc !== 2 || obs.rdata !== 32'd0 || obs.ex !== 1'b0) begin n_err++; $display("[TB] FAIL ertn_resp: got cyc %0d rdata %h ex %b want 2/0/0", obs.resp_cyc, obs.rdata, obs.ex); end
    n_cmp++; if (obs.hold_ok !== 1'b1) begin n_err++; $display("[TB] FAIL ertn_hold_stable: got %b want 1", obs.hold_ok); end
    n_cmp++; if (obs.re_cnt !== 0 || obs.we_cnt !== 0) begin n_err++; $display("[TB] FAIL ertn_no_access: got re %0d we %0d want 0/0", obs.re_cnt, obs.we_cnt); end
  endtask

  task automatic test_flush();
    bit quiet;
    // flush while the write strobe would be active
    start_req(WR, 14'h0031, 32'h7777_7777, 32'h0, 32'h1C00_0030, 2'd0);
    @(posedge clk); @(negedge clk);
    flush = 1'b1; #1;
    n_cmp++; if (csr_we !== 1'b0) begin n_err++; $display("[TB] FAIL flush_write_we: got %b want 0", csr_we); end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_write_idle: got %b want 1", req_ready); end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b0 || csr_we !== 1'b0) quiet = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("[TB] FAIL flush_write_no_resp: got %b want 1", quiet); end
    // flush in IDLE together with a handshake discards the request
    req_valid = 1'b1; req_op = RD; req_num = 14'h0032; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || csr_re !== 1'b0) begin n_err++; $display("[TB] FAIL flush_idle_discard: got ready %b re %b want 1/0", req_ready, csr_re); end
    // flush in RESP drops the response
    start_req(RD, 14'h0032, 32'h0, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < 6 && !resp_valid; i++) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL flush_resp_reach: got %b want 1", resp_valid); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_resp_drop: got valid %b ready %b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_priv();
    csr_mem[6'h33] = 32'h0BAD_0BAD;
    run_txn(WR, 14'h0033, 32'h0000_A5A5, 32'h0, 32'h1C00_0100, 2'd3, 1);
`ifdef CSR_PRIV_CHECK_EN
    n_cmp++; if (obs.ex_cnt !== 1 || obs.ex_cyc !== 1 || obs.ex_code !== 6'h0E || obs.ex_pc !== 32'h1C00_0100) begin n_err++; $display("[TB] FAIL priv_wb_ex: got cnt %0d cyc %0d code %h pc %h want 1/1/0e/1c000100", obs.ex_cnt, obs.ex_cyc, obs.ex_code, obs.ex_pc); end
    n_cmp++; if (obs.re_cnt !== 0 || obs.we_cnt !== 0) begin n_err++; $display("[TB] FAIL priv_no_access: got re %0d we %0d want 0/0", obs.re_cnt, obs.we_cnt); end
    n_cmp++; if (obs.resp_cyc !== 2 || obs.ex !== 1'b1 || obs.rdata !== 32'd0) begin n_err++; $display("[TB] FAIL priv_resp: got cyc %0d ex %b rdata %h want 2/1/0", obs.resp_cyc, obs.ex, obs.rdata); end
`else
    n_cmp++; if (obs.ex_cnt !== 0 || obs.we_cnt !== 1) begin n_err++; $display("[TB] FAIL nopriv_write: got ex %0d we %0d want 0/1", obs.ex_cnt, obs.we_cnt); end
    n_cmp++; if (obs.resp_cyc !== 3 || obs.ex !== 1'b0 || obs.rdata !== 32'h0BAD_0BAD) begin n_err++; $display("[TB] FAIL nopriv_resp: got cyc %0d ex %b rdata %h want 3/0/0bad0bad", obs.resp_cyc, obs.ex, obs.rdata); end
    n_cmp++; if (csr_mem[6'h33] !== 32'h0000_A5A5) begin n_err++; $display("[TB] FAIL nopriv_csr_value: got %h want 0000a5a5", csr_mem[6'h33]); end
`endif
  endtask

  task automatic test_rst_in_read();
    start_req(RD, 14'h0032, 32'h0, 32'h0, 32'h0, 2'd0);
    n_cmp++; if (csr_re !== 1'b1) begin n_err++; $display("[TB] FAIL rst_read_entry: got %b want 1", csr_re); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({req_ready, others} !== '0) begin n_err++; $display("[TB] FAIL rst_read_outputs: got %h want 0", {req_ready, others}); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    csr_mem[6'h30] = 32'h0F0F_1234;
    run_txn(RD, 14'h0030, 32'h0, 32'h0, 32'h0, 2'd0, 0);
    n_cmp++; if (obs.resp_cyc !== 2 || obs.rdata !== 32'h0F0F_1234) begin n_err++; $display("[TB] FAIL rst_read_recover: got cyc %0d rdata %h want 2/0f0f1234", obs.resp_cyc, obs.rdata); end
  endtask

  // Randomised back-to-back traffic against the transaction model
  task automatic test_random_back_to_back();
    logic [13:0] nums [8];
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rd, rj, pc, old;
    logic [1:0]  plv;
    exp_t e;
    nums = '{14'h0000, 14'h0001, 14'h0004, 14'h0005, 14'h0006, 14'h0030, 14'h0031, 14'h0032};
    for (int t = 0; t < 40; t++) begin
      op  = 2'($urandom_range(0, 3));
      num = nums[$urandom_range(0, 7)];
      rd  = $urandom; rj = $urandom; pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      plv = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      old = csr_mem[num[5:0]];
      e = model(op, rd, rj, old, plv);
      run_txn(op, num, rd, rj, pc, plv, int'($urandom_range(0, 3)));
      n_cmp++; if (obs.start_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rand_ready t%0d: got 0 want 1", t); end
      n_cmp++; if (obs.resp_cyc !== e.lat) begin n_err++; $display("[TB] FAIL rand_latency t%0d op%0d: got %0d want %0d", t, op, obs.resp_cyc, e.lat); end
      n_cmp++; if (obs.re_cnt !== e.re_cnt || (e.re_cnt == 1 && obs.re_cyc !== 1)) begin n_err++; $display("[TB] FAIL rand_re t%0d: got cnt %0d cyc %0d want %0d/1", t, obs.re_cnt, obs.re_cyc, e.re_cnt); end
      n_cmp++; if (obs.we_cnt !== e.we_cnt || (e.we_cnt == 1 && (obs.we_cyc !== 2 || obs.we_mask !== e.mask || obs.we_val !== e.wval))) begin n_err++; $display("[TB] FAIL rand_we t%0d: got cnt %0d cyc %0d mask %h val %h want %0d/2/%h/%h", t, obs.we_cnt, obs.we_cyc, obs.we_mask, obs.we_val, e.we_cnt, e.mask, e.wval); end
      n_cmp++; if (obs.ertn_cnt !== e.ertn_cnt || (e.ertn_cnt == 1 && obs.ertn_cyc !== 1)) begin n_err++; $display("[TB] FAIL rand_ertn t%0d: got %0d want %0d", t, obs.ertn_cnt, e.ertn_cnt); end
      n_cmp++; if (obs.ex_cnt !== e.ex_cnt || (e.ex_cnt == 1 && (obs.ex_code !== 6'h0E || obs.ex_pc !== pc))) begin n_err++; $display("[TB] FAIL rand_wb_ex t%0d: got cnt %0d code %h pc %h want %0d/0e/%h", t, obs.ex_cnt, obs.ex_code, obs.ex_pc, e.ex_cnt, pc); end
      n_cmp++; if (obs.rdata !== e.rdata || obs.ex !== e.ex) begin n_err++; $display("[TB] FAIL rand_resp t%0d: got %h/%b want %h/%b", t, obs.rdata, obs.ex, e.rdata, e.ex); end
      n_cmp++; if (csr_mem[num[5:0]] !== e.newval) begin n_err++; $display("[TB] FAIL rand_csr_value t%0d: got %h want %h", t, csr_mem[num[5:0]], e.newval); end
      n_cmp++; if (obs.hold_ok !== 1'b1 || obs.side_ok !== 1'b1) begin n_err++; $display("[TB] FAIL rand_stable_side t%0d: got hold %b side %b want 1/1", t, obs.hold_ok, obs.side_ok); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) csr_mem[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_csrrd_save0();
    test_csrxchg_ecfg();
    test_ertn_hold();
    test_flush();
    test_priv();
    test_rst_in_read();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
